// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between packet producers, the UART_tx byte sender
// and the round-robin transmit arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int PKT_BYTES = 4
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*PKT_BYTES*8-1:0] pkt_data;
   logic [NUM_REQ-1:0]             ack;
   logic [NUM_REQ-1:0]             grant;
   logic                           busy;
   logic                           tx_trmt;
   logic [7:0]                     tx_data;
   logic                           tx_done;

   modport master (
      output req, pkt_data, tx_done,
      input  ack, grant, busy, tx_trmt, tx_data
   );

   modport slave (
      input  req, pkt_data, tx_done,
      output ack, grant, busy, tx_trmt, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_tx between NUM_REQ packet sources;
// latches the winning packet and streams it out byte 0 first.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int PKT_BYTES = 4
) (
   input logic               clk,
   input logic               rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
   localparam int PKT_W = PKT_BYTES * 8;

   localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    win_q, win_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]    byte_idx_q, byte_idx_d;
   logic [PKT_W-1:0] pkt_q, pkt_d;

   logic             found;
   logic [PW-1:0]    pick;
   logic             last_byte;

   // Scan starting at rr_ptr so the last winner is always checked last
   always_comb begin
      int            idx_i;
      logic [PW-1:0] idx_p;
      found = 1'b0;
      pick  = rr_ptr_q;
      idx_i = 0;
      idx_p = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_i = int'(rr_ptr_q) + k;
         if (idx_i >= NUM_REQ) begin
            idx_i = idx_i - NUM_REQ;
         end
         idx_p = PW'(idx_i);
         if (!found && bus.req[idx_p]) begin
            found = 1'b1;
            pick  = idx_p;
         end
      end
   end

   assign last_byte = (byte_idx_q == LAST_BYTE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = SEND;
            end
         end
         SEND: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.tx_done) begin
               state_d = last_byte ? DONE : SEND;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q      <= '0;
         rr_ptr_q   <= '0;
         byte_idx_q <= '0;
         pkt_q      <= '0;
      end else begin
         win_q      <= win_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_idx_q <= byte_idx_d;
         pkt_q      <= pkt_d;
      end
   end

   // Packet is sampled only on the IDLE->SEND edge
   always_comb begin
      win_d      = win_q;
      rr_ptr_d   = rr_ptr_q;
      byte_idx_d = byte_idx_q;
      pkt_d      = pkt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               win_d      = pick;
               byte_idx_d = '0;
               pkt_d      = bus.pkt_data[int'(pick)*PKT_W +: PKT_W];
            end
         end
         WAIT: begin
            if (bus.tx_done && !last_byte) begin
               byte_idx_d = byte_idx_q + BW'(1);
            end
         end
         DONE: begin
            rr_ptr_d = (win_q == LAST_REQ) ? '0 : win_q + PW'(1);
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      bus.grant   = '0;
      bus.ack     = '0;
      bus.busy    = 1'b0;
      bus.tx_trmt = 1'b0;
      bus.tx_data = 8'h00;
      unique case (state_q)
         SEND: begin
            bus.busy       = 1'b1;
            bus.grant[win_q] = 1'b1;
            bus.tx_trmt    = 1'b1;
            bus.tx_data    = pkt_q[{byte_idx_q, 3'b000} +: 8];
         end
         WAIT: begin
            bus.busy       = 1'b1;
            bus.grant[win_q] = 1'b1;
            bus.tx_data    = pkt_q[{byte_idx_q, 3'b000} +: 8];
         end
         DONE: begin
            bus.busy       = 1'b1;
            bus.grant[win_q] = 1'b1;
            bus.ack[win_q]   = 1'b1;
         end
         default: begin
         end
      endcase
   end
endmodule
